// File: rtl/pic_seq_core.sv
// Multi-cycle PIC-style core: FETCH/EXEC sequencer fed by an external program ROM over
// a req/ack handshake, with W accumulator, file-register RAM, Z/C flags and a return stack.

module pic_seq_core #(
    parameter int unsigned DW          = 8,
    parameter int unsigned PAW         = 9,
    parameter int unsigned RAW         = 5,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic           CK,
    input  logic           CLR,
    input  logic           run,
    output logic           prog_req,
    output logic [PAW-1:0] prog_addr,
    input  logic           prog_ack,
    input  logic [11:0]    prog_data,
    output logic [PAW-1:0] pc,
    output logic [DW-1:0]  w_out,
    output logic           z_flag,
    output logic           c_flag,
    output logic           stk_err,
    output logic           retire
);

    localparam int unsigned IW        = 12;
    localparam int unsigned RAM_DEPTH = 1 << RAW;
    localparam int unsigned SPW       = $clog2(STACK_DEPTH + 1);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_t;

    state_t                          state;
    state_t                          state_n;
    logic [IW-1:0]                   ir;
    logic [IW-1:0]                   ir_n;
    logic [PAW-1:0]                  pc_n;
    logic [PAW-1:0]                  pc_inc;
    logic [DW-1:0]                   w_n;
    logic                            z_n;
    logic                            c_n;
    logic                            err_n;
    logic                            skip;
    logic                            skip_n;
    logic                            req_n;
    logic                            retire_n;
    logic [SPW-1:0]                  sp;
    logic [SPW-1:0]                  sp_n;
    logic [STACK_DEPTH-1:0][PAW-1:0] stk;
    logic [STACK_DEPTH-1:0][PAW-1:0] stk_n;
    logic [DW-1:0]                   ram [RAM_DEPTH];

    logic [3:0]                      op;
    logic [RAW-1:0]                  f;
    logic                            d;
    logic [DW-1:0]                   lit;
    logic [DW-1:0]                   fval;
    logic [DW:0]                     sum;
    logic [DW-1:0]                   res;
    logic                            wr_dest;
    logic                            ram_we;
    logic [DW-1:0]                   ram_wdata;

    // Instruction field decode and shared datapath terms
    assign op        = ir[11:8];
    assign f         = ir[RAW-1:0];
    assign d         = ir[5];
    assign lit       = DW'(ir[7:0]);
    assign fval      = ram[f];
    assign sum       = {1'b0, fval} + {1'b0, w_out};
    assign pc_inc    = pc + PAW'(1);
    assign prog_addr = pc;

    // Next-state, datapath and output decode
    always_comb begin
        state_n   = state;
        ir_n      = ir;
        pc_n      = pc;
        w_n       = w_out;
        z_n       = z_flag;
        c_n       = c_flag;
        err_n     = stk_err;
        skip_n    = skip;
        sp_n      = sp;
        stk_n     = stk;
        req_n     = 1'b0;
        retire_n  = 1'b0;
        res       = '0;
        wr_dest   = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = w_out;

        case (state)
            S_FETCH: begin
                if (prog_req && prog_ack) begin
                    ir_n    = prog_data;
                    state_n = S_EXEC;
                end else begin
                    req_n = run;
                end
            end
            S_EXEC: begin
                state_n  = S_FETCH;
                req_n    = run;
                retire_n = 1'b1;
                pc_n     = pc_inc;
                if (skip) begin
                    skip_n = 1'b0;
                end else begin
                    case (op)
                        4'h0: begin
                            if (ir == 12'h008) begin
                                if (sp == '0) begin
                                    err_n = 1'b1;
                                end else begin
                                    pc_n  = stk[0];
                                    stk_n = {PAW'(0), stk[STACK_DEPTH-1:1]};
                                    sp_n  = sp - SPW'(1);
                                end
                            end
                        end
                        4'h1: begin
                            res     = sum[DW-1:0];
                            c_n     = sum[DW];
                            z_n     = (sum[DW-1:0] == '0);
                            wr_dest = 1'b1;
                        end
                        4'h2: begin
                            res     = fval ^ w_out;
                            z_n     = ((fval ^ w_out) == '0);
                            wr_dest = 1'b1;
                        end
                        4'h3: begin
                            res     = fval;
                            z_n     = (fval == '0);
                            wr_dest = 1'b1;
                        end
                        4'h4: begin
                            ram_we    = 1'b1;
                            ram_wdata = w_out;
                        end
                        4'h5: begin
                            res     = fval + DW'(1);
                            wr_dest = 1'b1;
                            if ((fval + DW'(1)) == '0) begin
                                skip_n = 1'b1;
                            end
                        end
                        4'h6: begin
                            res     = fval & w_out;
                            z_n     = ((fval & w_out) == '0);
                            wr_dest = 1'b1;
                        end
                        // Shift-in push: a full stack drops its oldest entry
                        4'h9: begin
                            stk_n = {stk[STACK_DEPTH-2:0], pc_inc};
                            if (sp == SPW'(STACK_DEPTH)) begin
                                err_n = 1'b1;
                            end else begin
                                sp_n = sp + SPW'(1);
                            end
                            pc_n = PAW'(ir[7:0]);
                        end
                        4'hA, 4'hB: begin
                            pc_n = PAW'(ir[8:0]);
                        end
                        4'hC: begin
                            w_n = lit;
                        end
                        4'hE: begin
                            w_n = w_out ^ lit;
                            z_n = ((w_out ^ lit) == '0);
                        end
                        default: begin
                        end
                    endcase
                    if (wr_dest) begin
                        if (d) begin
                            ram_we    = 1'b1;
                            ram_wdata = res;
                        end else begin
                            w_n = res;
                        end
                    end
                end
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase
    end

    // State and architectural registers
    always_ff @(posedge CK) begin
        if (CLR) begin
            state    <= S_FETCH;
            ir       <= '0;
            pc       <= '0;
            w_out    <= '0;
            z_flag   <= 1'b0;
            c_flag   <= 1'b0;
            stk_err  <= 1'b0;
            skip     <= 1'b0;
            sp       <= '0;
            stk      <= '0;
            prog_req <= 1'b0;
            retire   <= 1'b0;
        end else begin
            state    <= state_n;
            ir       <= ir_n;
            pc       <= pc_n;
            w_out    <= w_n;
            z_flag   <= z_n;
            c_flag   <= c_n;
            stk_err  <= err_n;
            skip     <= skip_n;
            sp       <= sp_n;
            stk      <= stk_n;
            prog_req <= req_n;
            retire   <= retire_n;
        end
    end

    // File registers keep their contents through CLR; an aborted EXEC never writes
    always_ff @(posedge CK) begin
        if (ram_we && !CLR) begin
            ram[f] <= ram_wdata;
        end
    end

endmodule

// File: tb/tb_pic_seq_core.sv
// Bench for pic_seq_core: hand vector table, multi-cycle corner sequences and a random
// program run checked against an instruction-level reference model.

module tb_pic_seq_core;

    logic        CK = 1'b0;
    logic        CLR;
    logic        run;
    logic        prog_req;
    logic [8:0]  prog_addr;
    logic        prog_ack;
    logic [11:0] prog_data;
    logic [8:0]  pc;
    logic [7:0]  w_out;
    logic        z_flag;
    logic        c_flag;
    logic        stk_err;
    logic        retire;

    pic_seq_core dut (
        .CK(CK), .CLR(CLR), .run(run), .prog_req(prog_req), .prog_addr(prog_addr),
        .prog_ack(prog_ack), .prog_data(prog_data), .pc(pc), .w_out(w_out),
        .z_flag(z_flag), .c_flag(c_flag), .stk_err(stk_err), .retire(retire)
    );

    initial forever #5 CK = ~CK;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] rom [512];
    int          wait_cyc  = 0;
    bit          rand_wait = 1'b0;

    // Instruction-level reference state
    int mpc, mw, mz, mc, merr, mskip;
    int mram [32];
    int mstk [$];

    typedef struct {
        logic [11:0] instr;
        logic [7:0]  w;
        logic        z;
        logic        c;
    } vec_t;

    vec_t tbl [28];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mpc = 0; mw = 0; mz = 0; mc = 0; merr = 0; mskip = 0;
        mstk.delete();
    endtask

    task automatic model_step();
        logic [11:0] ir;
        int op, f, d, k, fv, r, nxt;
        bit wr;
        ir  = rom[mpc];
        nxt = (mpc + 1) % 512;
        op  = int'(ir[11:8]);
        f   = int'(ir[4:0]);
        d   = int'(ir[5]);
        k   = int'(ir[7:0]);
        fv  = mram[f];
        r   = 0;
        wr  = 1'b0;
        mpc = nxt;
        if (mskip != 0) begin
            mskip = 0;
            return;
        end
        case (op)
            0: if (ir == 12'h008) begin
                   if (mstk.size() == 0) merr = 1;
                   else mpc = mstk.pop_front();
               end
            1: begin r = fv + mw; mc = (r > 255); r = r % 256; mz = (r == 0); wr = 1'b1; end
            2: begin r = fv ^ mw; mz = (r == 0); wr = 1'b1; end
            3: begin r = fv; mz = (r == 0); wr = 1'b1; end
            4: mram[f] = mw;
            5: begin r = (fv + 1) % 256; wr = 1'b1; if (r == 0) mskip = 1; end
            6: begin r = fv & mw; mz = (r == 0); wr = 1'b1; end
            9: begin
                   mstk.push_front(nxt);
                   if (mstk.size() > 4) begin
                       void'(mstk.pop_back());
                       merr = 1;
                   end
                   mpc = k;
               end
            10, 11: mpc = int'(ir[8:0]);
            12: mw = k;
            14: begin mw = mw ^ k; mz = (mw == 0); end
            default: ;
        endcase
        if (wr) begin
            if (d != 0) mram[f] = r;
            else mw = r;
        end
    endtask

    // Program memory responder with programmable wait states
    initial begin
        int cnt;
        int cur_wait;
        cnt = 0; cur_wait = 0;
        prog_ack = 1'b0; prog_data = '0;
        forever begin
            @(negedge CK);
            if (prog_ack) begin
                prog_ack  = 1'b0;
                prog_data = 12'($urandom);
                cnt       = 0;
                cur_wait  = rand_wait ? int'($urandom_range(0, 2)) : wait_cyc;
            end else if (prog_req === 1'b1) begin
                if (cnt >= cur_wait) begin
                    prog_ack  = 1'b1;
                    prog_data = rom[prog_addr];
                end else begin
                    cnt++;
                    prog_data = 12'($urandom);
                end
            end else begin
                cnt      = 0;
                cur_wait = rand_wait ? int'($urandom_range(0, 2)) : wait_cyc;
            end
        end
    end

    // Retire monitor: step the model and compare architectural state
    initial forever begin
        @(posedge CK);
        #1;
        if (retire === 1'b1) begin
            model_step();
            chk("m_pc",  32'(pc),      mpc);
            chk("m_w",   32'(w_out),   mw);
            chk("m_z",   32'(z_flag),  mz);
            chk("m_c",   32'(c_flag),  mc);
            chk("m_err", 32'(stk_err), merr);
        end
        if (prog_req === 1'b1) chk("m_addr", 32'(prog_addr), mpc);
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic clr_on();
        @(negedge CK);
        CLR = 1'b1;
        @(negedge CK);
        model_reset();
    endtask

    task automatic clr_off();
        @(negedge CK);
        CLR = 1'b0;
    endtask

    task automatic wait_retire(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(posedge CK);
            #1;
            cyc++;
        end while (retire !== 1'b1 && cyc < budget);
        if (retire !== 1'b1) chk("retire_timeout", 32'(retire), 1);
    endtask

    function automatic logic [11:0] rnd_instr();
        logic [7:0] lo;
        logic [8:0] tgt;
        lo  = 8'($urandom);
        tgt = 9'($urandom);
        case ($urandom_range(0, 15))
            0, 1:    return 12'h008;
            2:       return {4'h1, lo};
            3:       return {4'h2, lo};
            4:       return {4'h3, lo};
            5:       return {4'h4, lo};
            6, 14:   return {4'h5, lo};
            7:       return {4'h6, lo};
            8:       return {4'h9, lo};
            9:       return {3'b101, tgt};
            11:      return {4'hE, lo};
            12:      return {4'h0, lo};
            13:      return {4'h7, lo};
            default: return {4'hC, lo};
        endcase
    endfunction

    initial begin
        int cyc;
        int exp_pc [10];
        int exp_err [10];

        tbl[0]  = '{12'hCFF, 8'hFF, 1'b0, 1'b0};
        tbl[1]  = '{12'h403, 8'hFF, 1'b0, 1'b0};
        tbl[2]  = '{12'hC01, 8'h01, 1'b0, 1'b0};
        tbl[3]  = '{12'h103, 8'h00, 1'b1, 1'b1};
        tbl[4]  = '{12'h303, 8'hFF, 1'b0, 1'b1};
        tbl[5]  = '{12'hE0F, 8'hF0, 1'b0, 1'b1};
        tbl[6]  = '{12'h603, 8'hF0, 1'b0, 1'b1};
        tbl[7]  = '{12'h223, 8'hF0, 1'b0, 1'b1};
        tbl[8]  = '{12'h303, 8'h0F, 1'b0, 1'b1};
        tbl[9]  = '{12'hC80, 8'h80, 1'b0, 1'b1};
        tbl[10] = '{12'h404, 8'h80, 1'b0, 1'b1};
        tbl[11] = '{12'h124, 8'h80, 1'b1, 1'b1};
        tbl[12] = '{12'h304, 8'h00, 1'b1, 1'b1};
        tbl[13] = '{12'hC33, 8'h33, 1'b1, 1'b1};
        tbl[14] = '{12'h103, 8'h42, 1'b0, 1'b0};
        tbl[15] = '{12'hE42, 8'h00, 1'b1, 1'b0};
        tbl[16] = '{12'h000, 8'h00, 1'b1, 1'b0};
        tbl[17] = '{12'h7AB, 8'h00, 1'b1, 1'b0};
        tbl[18] = '{12'hCFF, 8'hFF, 1'b1, 1'b0};
        tbl[19] = '{12'h402, 8'hFF, 1'b1, 1'b0};
        tbl[20] = '{12'h522, 8'hFF, 1'b1, 1'b0};
        tbl[21] = '{12'hC55, 8'hFF, 1'b1, 1'b0};
        tbl[22] = '{12'hC11, 8'h11, 1'b1, 1'b0};
        tbl[23] = '{12'h302, 8'h00, 1'b1, 1'b0};
        tbl[24] = '{12'h502, 8'h01, 1'b1, 1'b0};
        tbl[25] = '{12'hC77, 8'h77, 1'b1, 1'b0};
        tbl[26] = '{12'h302, 8'h00, 1'b1, 1'b0};
        tbl[27] = '{12'h323, 8'h00, 1'b0, 1'b0};

        CLR = 1'b1;
        run = 1'b1;
        model_reset();

        // Reset behaviour and first fetch
        clr_on();
        for (int a = 0; a < 512; a++) rom[a] = 12'h000;
        for (int i = 0; i < 28; i++) rom[i] = tbl[i].instr;
        chk("rst_req",    32'(prog_req), 0);
        chk("rst_pc",     32'(pc),       0);
        chk("rst_w",      32'(w_out),    0);
        chk("rst_z",      32'(z_flag),   0);
        chk("rst_c",      32'(c_flag),   0);
        chk("rst_err",    32'(stk_err),  0);
        chk("rst_retire", 32'(retire),   0);
        clr_off();
        @(posedge CK); #1;
        chk("rel_req",  32'(prog_req),  1);
        chk("rel_addr", 32'(prog_addr), 0);

        // ALU, flags and skip vectors at zero wait states
        for (int i = 0; i < 28; i++) begin
            wait_retire(20, cyc);
            chk("tbl_spacing", cyc, 2);
            chk("tbl_pc", 32'(pc),     i + 1);
            chk("tbl_w",  32'(w_out),  32'(tbl[i].w));
            chk("tbl_z",  32'(z_flag), 32'(tbl[i].z));
            chk("tbl_c",  32'(c_flag), 32'(tbl[i].c));
        end

        // Wait states and run gating
        clr_on();
        for (int a = 0; a < 512; a++) rom[a] = 12'h000;
        wait_cyc = 3;
        clr_off();
        wait_retire(40, cyc);
        for (int i = 0; i < 3; i++) begin
            wait_retire(40, cyc);
            chk("ws_spacing", cyc, 5);
        end
        @(negedge CK);
        run = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CK); #1;
            chk("hold_req", 32'(prog_req), 0);
            chk("hold_pc",  32'(pc),       4);
        end
        @(negedge CK);
        run = 1'b1;
        wait_retire(40, cyc);
        chk("resume_pc", 32'(pc), 5);
        wait_cyc = 0;

        // Nested calls past the stack depth, then unwinding
        clr_on();
        for (int a = 0; a < 512; a++) rom[a] = 12'h000;
        rom[9'h000] = 12'h910; rom[9'h010] = 12'h920; rom[9'h020] = 12'h930;
        rom[9'h030] = 12'h940; rom[9'h040] = 12'h950; rom[9'h050] = 12'h008;
        rom[9'h041] = 12'h008; rom[9'h031] = 12'h008; rom[9'h021] = 12'h008;
        rom[9'h011] = 12'h008;
        exp_pc  = '{'h10, 'h20, 'h30, 'h40, 'h50, 'h41, 'h31, 'h21, 'h11, 'h12};
        exp_err = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        clr_off();
        for (int i = 0; i < 10; i++) begin
            wait_retire(20, cyc);
            chk("stk_pc",  32'(pc),      exp_pc[i]);
            chk("stk_err", 32'(stk_err), exp_err[i]);
        end
        clr_on();
        chk("err_clr", 32'(stk_err), 0);

        // PC wrap through GOTO to the last address
        for (int a = 0; a < 512; a++) rom[a] = 12'h000;
        rom[0]      = 12'hBFF;
        rom[9'h1FF] = 12'h000;
        clr_off();
        wait_retire(20, cyc);
        chk("goto_pc", 32'(pc), 'h1FF);
        wait_retire(20, cyc);
        chk("wrap_pc",   32'(pc),        0);
        chk("wrap_addr", 32'(prog_addr), 0);

        // CLR in the middle of EXEC aborts the instruction
        clr_on();
        rom[0] = 12'hC5A;
        rom[1] = 12'hC5A;
        clr_off();
        @(posedge CK); #1;
        @(posedge CK); #1;
        chk("exec_req", 32'(prog_req), 0);
        @(negedge CK);
        CLR = 1'b1;
        @(posedge CK); #1;
        chk("mid_pc",     32'(pc),       0);
        chk("mid_w",      32'(w_out),    0);
        chk("mid_retire", 32'(retire),   0);
        chk("mid_req",    32'(prog_req), 0);

        // CLR coinciding with a pending ack: the ack is dropped
        clr_off();
        @(posedge CK); #1;
        @(negedge CK);
        CLR = 1'b1;
        @(posedge CK); #1;
        chk("fclr_req", 32'(prog_req), 0);
        @(posedge CK); #1;
        chk("fclr_retire", 32'(retire), 0);
        chk("fclr_w",      32'(w_out),  0);
        clr_off();
        wait_retire(20, cyc);
        chk("fclr_after_w",  32'(w_out), 'h5A);
        chk("fclr_after_pc", 32'(pc),    1);

        // Random program with random wait states against the reference model
        clr_on();
        for (int a = 0; a < 512; a++) rom[a] = rnd_instr();
        for (int i = 0; i < 32; i++) begin
            rom[2*i]     = {4'hC, 8'($urandom)};
            rom[2*i + 1] = 12'h400 | 12'(i);
        end
        rand_wait = 1'b1;
        clr_off();
        for (int i = 0; i < 700; i++) begin
            wait_retire(20, cyc);
            if (retire !== 1'b1) break;
        end
        rand_wait = 1'b0;

        @(negedge CK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
